mem_wb_stage: RTL and testbench

Memory-access and write-back stage placed directly downstream of the execution stage. It consumes the registered ALU result, store data and flags, performs data-memory loads and stores, and drives the register-file write port. It also latches the HLT condition for the fetch stage. All ops share a fixed two-cycle latency, so write-back order always matches issue order.

---
 rtl/mem_wb_stage.sv | 138 +++++++++++++
 tb/tb_mem_wb_stage.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: data-memory access (M) and register-file write-back (W).
// Every op takes exactly two edges from capture to wb_*, so write-backs
// retire in issue order. HLT latches a sticky halted flag that blocks all
// further stores and write-backs until reset.
module mem_wb_stage #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_W   = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_ex,
  input  logic [5:0]      op_ex,
  input  logic [RD_W-1:0] rd_ex,
  input  logic [15:0]     ans_ex,
  input  logic [15:0]     DM_data,
  input  logic [1:0]      flag_ex,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_addr,
  output logic [15:0]     wb_data,
  output logic [1:0]      wb_flag,
  output logic            halted
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ALU  = 2'd1,
    CLS_LD   = 2'd2
  } cls_e;

  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       rdata_q;
  logic [ADDR_W-1:0] addr;

  logic              halted_q, halted_d;
  logic              accept;
  logic              is_st, is_hlt;
  cls_e              cls_d;

  logic              m_valid_q;
  cls_e              m_cls_q;
  logic [RD_W-1:0]   m_rd_q;
  logic [15:0]       m_ans_q;
  logic [1:0]        m_flag_q;

  logic              wb_en_q, wb_en_d;
  logic [RD_W-1:0]   wb_addr_q;
  logic [15:0]       wb_data_q, wb_data_d;
  logic [1:0]        wb_flag_q;

  // Opcode decode into write-back class plus store/halt strobes.
  always_comb begin
    cls_d  = CLS_NONE;
    is_st  = 1'b0;
    is_hlt = 1'b0;
    case (op_ex)
      6'h00, 6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
      6'h16, 6'h19, 6'h1A, 6'h1B: cls_d = CLS_ALU;
      6'h14:                      cls_d = CLS_LD;
      6'h15:                      is_st = 1'b1;
      6'h11:                      is_hlt = 1'b1;
      default:                    cls_d = CLS_NONE;
    endcase
  end

  // Input acceptance, halt latch and W-stage next values.
  always_comb begin
    accept   = valid_ex && !halted_q;
    addr     = ans_ex[ADDR_W-1:0];
    halted_d = halted_q || (accept && is_hlt);
    wb_en_d  = m_valid_q && (m_cls_q != CLS_NONE);
    wb_data_d = '0;
    if (wb_en_d) begin
      wb_data_d = (m_cls_q == CLS_LD) ? rdata_q : m_ans_q;
    end
  end

  // Data memory: store and synchronous read; contents survive reset.
  // A store in a reset cycle is suppressed by qualifying on reset.
  always_ff @(posedge clk) begin
    if (reset && accept && is_st) begin
      mem_q[addr] <= DM_data;
    end
    rdata_q <= mem_q[addr];
  end

  // Sticky halt flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // M-stage register: captures the accepted op's class and payload.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_cls_q   <= CLS_NONE;
      m_rd_q    <= '0;
      m_ans_q   <= '0;
      m_flag_q  <= '0;
    end else begin
      m_valid_q <= accept;
      m_cls_q   <= accept ? cls_d : CLS_NONE;
      if (accept) begin
        m_rd_q   <= rd_ex;
        m_ans_q  <= ans_ex;
        m_flag_q <= flag_ex;
      end
    end
  end

  // W-stage register driving the register-file write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_flag_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= m_rd_q;
      wb_data_q <= wb_data_d;
      wb_flag_q <= m_flag_q;
    end
  end

  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_flag = wb_flag_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver pushes each expected
// write-back; the monitor pops on every wb_en and flags unexpected ones.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex;
  logic [5:0]  op_ex;
  logic [3:0]  rd_ex;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic [1:0]  flag_ex;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [1:0]  wb_flag;
  logic        halted;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
    logic [1:0]  flag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  mem_wb_stage #(.ADDR_W(8), .RD_W(4)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .op_ex(op_ex),
    .rd_ex(rd_ex), .ans_ex(ans_ex), .DM_data(DM_data), .flag_ex(flag_ex),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_flag(wb_flag), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Drive one op for one cycle; return #1 after the capturing edge.
  task automatic issue(input logic v, input logic [5:0] op, input logic [3:0] rd,
                       input logic [15:0] ans, input logic [15:0] dm, input logic [1:0] fl,
                       input logic exp_en, input logic [15:0] exp_data);
    valid_ex = v; op_ex = op; rd_ex = rd; ans_ex = ans; DM_data = dm; flag_ex = fl;
    if (exp_en) exp_q.push_back('{rd: rd, data: exp_data, flag: fl});
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 6'h00, 4'h0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  // Monitor: starts after the first edge (which is a reset edge).
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wb", {28'h0, wb_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", {28'h0, wb_addr}, {28'h0, e.rd});
          check("wb_data", {16'h0, wb_data}, {16'h0, e.data});
          check("wb_flag", {30'h0, wb_flag}, {30'h0, e.flag});
        end
      end else begin
        check("wb_en_known", {31'h0, wb_en}, 32'h0);
        check("wb_data_idle_zero", {16'h0, wb_data}, 32'h0);
      end
    end
  end

  initial begin
    // Reset held with a valid ADD presented.
    reset = 1'b0;
    issue(1'b1, 6'h00, 4'h1, 16'h1111, 16'h0, 2'b11, 1'b0, 16'h0);
    check("reset_halted", {31'h0, halted}, 32'h0);
    issue(1'b1, 6'h00, 4'h1, 16'h1111, 16'h0, 2'b11, 1'b0, 16'h0);
    check("reset_halted2", {31'h0, halted}, 32'h0);
    check("reset_wb_en", {31'h0, wb_en}, 32'h0);
    reset = 1'b1;

    // ALU pass-through.
    issue(1'b1, 6'h00, 4'h3, 16'h1234, 16'h0, 2'b10, 1'b1, 16'h1234);
    // Store then load with address wrap (0x0105 -> 0x05).
    issue(1'b1, 6'h15, 4'h0, 16'h0105, 16'hBEEF, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h14, 4'h7, 16'h0005, 16'h0, 2'b01, 1'b1, 16'hBEEF);
    // No-write classes must not touch memory.
    issue(1'b1, 6'h1C, 4'h2, 16'h0005, 16'h1111, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h17, 4'h2, 16'h0005, 16'h2222, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h03, 4'h2, 16'h0005, 16'h3333, 2'b00, 1'b0, 16'h0);
    issue(1'b0, 6'h15, 4'h2, 16'h0005, 16'h4444, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h14, 4'h8, 16'h0205, 16'h0, 2'b10, 1'b1, 16'hBEEF);
    // Back-to-back ALU/LD mix.
    issue(1'b1, 6'h01, 4'h4, 16'h00FF, 16'h0, 2'b01, 1'b1, 16'h00FF);
    issue(1'b1, 6'h19, 4'h5, 16'h8000, 16'h0, 2'b00, 1'b1, 16'h8000);
    issue(1'b1, 6'h14, 4'h9, 16'hFF05, 16'h0, 2'b11, 1'b1, 16'hBEEF);
    issue(1'b1, 6'h16, 4'h6, 16'h0042, 16'h0, 2'b10, 1'b1, 16'h0042);
    issue(1'b1, 6'h0F, 4'hA, 16'hA5A5, 16'h0, 2'b00, 1'b1, 16'hA5A5);
    idle(2);

    // Reset mid-stream: LD in M is dropped; store during reset is not done.
    issue(1'b1, 6'h15, 4'h0, 16'h0020, 16'hCAFE, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h14, 4'hA, 16'h0020, 16'h0, 2'b00, 1'b0, 16'h0);
    reset = 1'b0;
    issue(1'b1, 6'h15, 4'h0, 16'h0020, 16'hDEAD, 2'b00, 1'b0, 16'h0);
    idle(1);
    reset = 1'b1;
    issue(1'b1, 6'h14, 4'hB, 16'h0020, 16'h0, 2'b01, 1'b1, 16'hCAFE);
    check("halted_after_reset", {31'h0, halted}, 32'h0);

    // Halt: ADD rd1 retires, later ST and ADD rd2 are ignored.
    issue(1'b1, 6'h15, 4'h0, 16'h0010, 16'h1111, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h00, 4'h1, 16'h0AAA, 16'h0, 2'b00, 1'b1, 16'h0AAA);
    issue(1'b1, 6'h11, 4'h0, 16'h0000, 16'h0, 2'b00, 1'b0, 16'h0);
    check("halted_set", {31'h0, halted}, 32'h1);
    issue(1'b1, 6'h15, 4'h0, 16'h0010, 16'h5555, 2'b00, 1'b0, 16'h0);
    issue(1'b1, 6'h00, 4'h2, 16'h0BBB, 16'h0, 2'b00, 1'b0, 16'h0);
    idle(3);
    check("halted_sticky", {31'h0, halted}, 32'h1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("halted_cleared", {31'h0, halted}, 32'h0);
    issue(1'b1, 6'h14, 4'hC, 16'h0010, 16'h0, 2'b10, 1'b1, 16'h1111);
    idle(4);

    check("queue_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
